// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: state encoding and counter sizing shared by the serial adder
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/serial_adder_if.sv
// serial_adder_if: operand and result valid/ready channels of the serial adder
interface serial_adder_if #(parameter int WIDTH = 8);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout
    );

endinterface

// File: rtl/fa.sv
// fa: single-bit dataflow full-adder cell
module fa (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b ^ c;
    assign carry = (a & b) | (c & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder, one bit pair per clock through a full-adder cell
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    serial_adder_if.slave  bus,
    output logic           busy
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_r;
    logic [WIDTH-1:0] sum_nx;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_s;
    logic             fa_c;
    logic             in_rdy;

    fa u_fa (
        .a     (a_sh[0]),
        .b     (b_sh[0]),
        .c     (carry),
        .sum   (fa_s),
        .carry (fa_c)
    );

    assign in_rdy        = (state == IDLE) || (state == DONE && bus.out_ready);
    assign sum_nx        = WIDTH'({fa_s, sum_r} >> 1);
    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = (state == DONE);
    assign bus.sum       = sum_r;
    assign bus.cout      = carry;
    assign busy          = (state == RUN);

    // Handshake FSM with operand shifters, result shifter, carry and bit counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            sum_r <= '0;
            carry <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.in_valid && in_rdy) begin
                        a_sh  <= bus.a;
                        b_sh  <= bus.b;
                        carry <= bus.cin;
                        cnt   <= '0;
                        state <= RUN;
                    end else if (state == DONE && bus.out_ready) begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    sum_r <= sum_nx;
                    carry <= fa_c;
                    cnt   <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: scoreboard bench for serial_adder at WIDTH 8, 1 and 3
module tb_serial_adder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    // Edge counter used to measure latency from acceptance to out_valid
    always @(posedge clk) cyc <= cyc + 1;

    serial_adder_if #(.WIDTH(8)) if8 ();
    serial_adder_if #(.WIDTH(1)) if1 ();
    serial_adder_if #(.WIDTH(3)) if3 ();
    logic busy8, busy1, busy3;

    serial_adder #(.WIDTH(8)) u8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave), .busy(busy8));
    serial_adder #(.WIDTH(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave), .busy(busy1));
    serial_adder #(.WIDTH(3)) u3 (.clk(clk), .rst_n(rst_n), .bus(if3.slave), .busy(busy3));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    int   q8e[$], q8c[$], q1e[$], q1c[$], q3e[$], q3c[$];
    logic pv8 = 1'b0, pv1 = 1'b0, pv3 = 1'b0;
    int   e;

    // Scoreboard for WIDTH=8: push on input handshake, pop on output handshake
    always @(negedge clk) begin
        if (rst_n) begin
            if (if8.out_valid && !pv8) begin
                if (q8c.size() == 0) check("ov8_unexpected", 1, 0);
                else check("lat8", 64'(cyc - q8c[0]), 8);
            end
            if (if8.out_valid && if8.out_ready) begin
                if (q8e.size() == 0) check("res8_unexpected", 1, 0);
                else begin
                    e = q8e.pop_front();
                    void'(q8c.pop_front());
                    check("res8", {if8.cout, if8.sum}, 64'(e));
                end
            end
            if (if8.in_valid && if8.in_ready) begin
                q8e.push_back(int'(if8.a) + int'(if8.b) + int'(if8.cin));
                q8c.push_back(cyc + 1);
            end
            pv8 <= if8.out_valid;
        end else pv8 <= 1'b0;
    end

    // Scoreboard for WIDTH=1
    always @(negedge clk) begin
        if (rst_n) begin
            if (if1.out_valid && !pv1) begin
                if (q1c.size() == 0) check("ov1_unexpected", 1, 0);
                else check("lat1", 64'(cyc - q1c[0]), 1);
            end
            if (if1.out_valid && if1.out_ready) begin
                if (q1e.size() == 0) check("res1_unexpected", 1, 0);
                else begin
                    e = q1e.pop_front();
                    void'(q1c.pop_front());
                    check("res1", {if1.cout, if1.sum}, 64'(e));
                end
            end
            if (if1.in_valid && if1.in_ready) begin
                q1e.push_back(int'(if1.a) + int'(if1.b) + int'(if1.cin));
                q1c.push_back(cyc + 1);
            end
            pv1 <= if1.out_valid;
        end else pv1 <= 1'b0;
    end

    // Scoreboard for WIDTH=3
    always @(negedge clk) begin
        if (rst_n) begin
            if (if3.out_valid && !pv3) begin
                if (q3c.size() == 0) check("ov3_unexpected", 1, 0);
                else check("lat3", 64'(cyc - q3c[0]), 3);
            end
            if (if3.out_valid && if3.out_ready) begin
                if (q3e.size() == 0) check("res3_unexpected", 1, 0);
                else begin
                    e = q3e.pop_front();
                    void'(q3c.pop_front());
                    check("res3", {if3.cout, if3.sum}, 64'(e));
                end
            end
            if (if3.in_valid && if3.in_ready) begin
                q3e.push_back(int'(if3.a) + int'(if3.b) + int'(if3.cin));
                q3c.push_back(cyc + 1);
            end
            pv3 <= if3.out_valid;
        end else pv3 <= 1'b0;
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic c);
        int  n = 0;
        logic ok = 1'b0;
        if8.a = a;
        if8.b = b;
        if8.cin = c;
        if8.in_valid = 1'b1;
        while (!ok && n < 30) begin
            @(negedge clk);
            ok = if8.in_ready;
            tick();
            n++;
        end
        if (!ok) check("acc8_timeout", 0, 1);
        if8.in_valid = 1'b0;
    endtask

    task automatic wait_ov8();
        int n = 0;
        while (!if8.out_valid && n < 40) begin
            tick();
            n++;
        end
        if (!if8.out_valid) check("ov8_timeout", 0, 1);
    endtask

    logic saw;
    logic ok;
    int   n;

    initial begin
        {if8.in_valid, if8.a, if8.b, if8.cin, if8.out_ready} = '0;
        {if1.in_valid, if1.a, if1.b, if1.cin} = '0;
        {if3.in_valid, if3.a, if3.b, if3.cin} = '0;
        if1.out_ready = 1'b1;
        if3.out_ready = 1'b1;
        tick(3);
        check("rst_in_ready", if8.in_ready, 1);
        check("rst_out_valid", if8.out_valid, 0);
        check("rst_sum", if8.sum, 0);
        check("rst_cout", if8.cout, 0);
        check("rst_busy", busy8, 0);
        rst_n = 1'b1;
        tick();

        if8.out_ready = 1'b1;
        send8(8'h5A, 8'h33, 1'b0);
        tick(2);
        rst_n = 1'b0;
        #1;
        check("abort_in_ready", if8.in_ready, 1);
        check("abort_busy", busy8, 0);
        check("abort_out_valid", if8.out_valid, 0);
        check("abort_sum", if8.sum, 0);
        check("abort_cout", if8.cout, 0);
        q8e.delete();
        q8c.delete();
        tick(2);
        rst_n = 1'b1;
        tick();
        saw = 1'b0;
        repeat (12) begin
            saw |= if8.out_valid;
            tick();
        end
        check("abort_no_ov", saw, 0);

        send8(8'h5A, 8'h33, 1'b0);
        wait_ov8();
        check("basic_sum", if8.sum, 8'h8D);
        check("basic_cout", if8.cout, 0);
        tick();
        send8(8'hFF, 8'h01, 1'b0);
        wait_ov8();
        tick();
        send8(8'hFF, 8'hFF, 1'b1);
        wait_ov8();
        tick();

        if8.out_ready = 1'b0;
        send8(8'hAA, 8'h55, 1'b1);
        wait_ov8();
        repeat (5) begin
            if8.a = 8'($urandom);
            if8.b = 8'($urandom);
            if8.cin = 1'($urandom);
            if8.in_valid = ~if8.in_valid;
            @(negedge clk);
            check("bp_sum", if8.sum, 8'h00);
            check("bp_cout", if8.cout, 1);
            check("bp_in_ready", if8.in_ready, 0);
            tick();
        end
        if8.in_valid = 1'b0;
        if8.out_ready = 1'b1;
        tick();
        check("bp_ov_drop", if8.out_valid, 0);
        check("bp_idle", if8.in_ready, 1);
        check("bp_idle_busy", busy8, 0);
        check("bp_sum_kept", if8.sum, 8'h00);
        tick();

        send8(8'h12, 8'h34, 1'b0);
        wait_ov8();
        send8(8'h10, 8'h20, 1'b0);
        check("b2b_busy", busy8, 1);
        check("b2b_ov_low", if8.out_valid, 0);
        wait_ov8();
        check("b2b_sum", if8.sum, 8'h30);
        tick();

        for (int i = 0; i < 8; i++) begin
            if1.a = 1'(i);
            if1.b = 1'(i >> 1);
            if1.cin = 1'(i >> 2);
            if1.in_valid = 1'b1;
            ok = 1'b0;
            n = 0;
            while (!ok && n < 20) begin
                @(negedge clk);
                ok = if1.in_ready;
                tick();
                n++;
            end
            if (!ok) check("acc1_timeout", 0, 1);
        end
        if1.in_valid = 1'b0;

        for (int i = 0; i < 128; i++) begin
            if3.a = 3'(i);
            if3.b = 3'(i >> 3);
            if3.cin = 1'(i >> 6);
            if3.in_valid = 1'b1;
            ok = 1'b0;
            n = 0;
            while (!ok && n < 20) begin
                @(negedge clk);
                ok = if3.in_ready;
                tick();
                n++;
            end
            if (!ok) check("acc3_timeout", 0, 1);
        end
        if3.in_valid = 1'b0;

        n = 0;
        while ((q1e.size() + q3e.size() + q8e.size()) != 0 && n < 50) begin
            tick();
            n++;
        end
        check("drain", 64'(q1e.size() + q3e.size() + q8e.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
Bit-serial N-bit adder built around the team's single-bit dataflow full-adder cell.
- Accepts two WIDTH-bit operands and a carry-in through a valid/ready handshake.
- Feeds one bit pair per clock, LSB first, into the full adder, with the carry registered between cycles.
- Returns the WIDTH-bit sum and the carry-out through a second valid/ready handshake.
- Sits directly upstream of the full-adder cell, which it drives; it trades latency for area in the arithmetic datapath.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 1..64

Ports:
clk  input  1  single clock; all state updates on the rising edge
rst_n  input  1  reset, asynchronous, active-low
in_valid  input  1  operands a, b, cin are valid this cycle
in_ready  output  1  block can accept operands this cycle
a  input  WIDTH  operand A, captured on the input handshake
b  input  WIDTH  operand B, captured on the input handshake
cin  input  1  carry-in, captured on the input handshake
out_valid  output  1  sum and cout hold a completed result
out_ready  input  1  consumer accepts the result this cycle
sum  output  WIDTH  result bits, LSB is bit 0
cout  output  1  final carry-out
busy  output  1  high while in state RUN

Behaviour:
Reset (rst_n low, asynchronous): all registers clear immediately, independent of clk.
- state = IDLE; operand shift registers, sum register, carry register and bit counter = 0.
- Outputs: in_ready = 1, out_valid = 0, sum = 0, cout = 0, busy = 0.

States:
- IDLE: in_ready = 1. On in_valid & in_ready:
  - capture a, b into shift registers; load carry register with cin; clear counter;
  - go to RUN.
- RUN: in_ready = 0, busy = 1. Each cycle:
  - the full adder sees a_sh[0], b_sh[0] and the carry register;
  - its sum bit shifts into the MSB of the sum register (right shift);
  - its carry output loads the carry register;
  - a_sh and b_sh shift right by 1; counter increments.
  - On the cycle where counter == WIDTH-1, go to DONE.
- DONE: out_valid = 1. sum = sum register, cout = carry register; both stable until the output handshake.
  - On out_valid & out_ready: go to IDLE, unless the same cycle carries an input handshake (below).

Timing and handshake rules:
- Latency: input handshake at edge k gives out_valid high in the cycle after edge k+WIDTH. For WIDTH=8, the result is visible 8 cycles after acceptance.
- in_ready = (state == IDLE) | (state == DONE & out_ready). Back-to-back operation is allowed: a simultaneous output and input handshake in DONE captures new operands and goes directly to RUN.
- Operand inputs are ignored whenever in_ready is low; they have no effect mid-operation.
- out_ready while out_valid = 0 has no effect.
- in_valid may be held high across cycles; only one operation is accepted per handshake.
- After the output handshake, out_valid drops the next cycle. sum and cout keep their last values until the next operation overwrites them.

Arithmetic:
- {cout, sum} = a + b + cin, modulo 2^(WIDTH+1). The result is unsigned; overflow is reported solely through cout.

Boundary conditions:
- Counter width = max(1, clog2(WIDTH)). WIDTH=1: RUN lasts exactly one cycle.
- Reset asserted in RUN or DONE aborts the operation. No partial result is presented, and out_valid stays 0 after release.
- Release of rst_n is expected synchronous to clk, which is an integration requirement.

Decomposition:
- Shared package: state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the counter-width computation function.
- Sub-module: one instance of the team's full-adder cell fa (inputs a, b, c; outputs sum, carry), driven by the operand LSBs and the carry register.
- Everything else (FSM, shifters, counter) stays in serial_adder.

Test Plan:
- Reset mid-run: WIDTH=8, accept a=8'h5A, b=8'h33, cin=0, assert rst_n low at cycle 3 -> outputs immediately 0, in_ready=1, busy=0; no out_valid after release.
- Basic add: a=8'h5A, b=8'h33, cin=0, out_ready=1 -> out_valid exactly 8 cycles after acceptance, sum=8'h8D, cout=0.
- Full overflow: a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1. Separately, a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid while changing a/b and pulsing in_valid -> sum and cout stable, in_ready=0, no capture. Raise out_ready -> one handshake, then IDLE.
- Back-to-back: in DONE with out_ready=1 and in_valid=1 carrying a=8'h10, b=8'h20 -> new operation accepted in the same cycle; next result sum=8'h30 after 8 cycles with no idle bubble.
- Exhaustive at WIDTH=1 and WIDTH=3: all a, b, cin combinations against a reference model -> {cout, sum} matches a+b+cin for every case, latency = WIDTH.
